// File: rtl/gsim_pkg.sv
// Shared sizes, FSM encoding and band coefficients for the GSIM solver.
// The coefficients are consumed by gsim_update; the scheduler only moves operands.
package gsim_pkg;

    localparam int N  = 16;
    localparam int IW = $clog2(N);
    localparam int XW = 32;
    localparam int BW = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_OUT   = S_OUT
    } gsim_state_t;

    localparam logic signed [7:0] C0 = 8'sd20;
    localparam logic signed [7:0] C1 = -8'sd13;
    localparam logic signed [7:0] C2 = 8'sd6;
    localparam logic signed [7:0] C3 = -8'sd1;

    // Sign extension followed by <<16 leaves exactly b in the integer half.
    function automatic logic [XW-1:0] widen_b(input logic [BW-1:0] b);
        return {b, {(XW-BW){1'b0}}};
    endfunction

endpackage

// File: rtl/gsim_xfile.sv
// N x 32 solution register file: one write port, synchronous clear,
// a 7-tap window read around win_idx and an independent output read port.
module gsim_xfile
    import gsim_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [XW-1:0] wdata,
    input  logic [IW-1:0] win_idx,
    output logic [XW-1:0] tap_m3,
    output logic [XW-1:0] tap_m2,
    output logic [XW-1:0] tap_m1,
    output logic [XW-1:0] tap_p1,
    output logic [XW-1:0] tap_p2,
    output logic [XW-1:0] tap_p3,
    input  logic [IW-1:0] rd_idx,
    output logic [XW-1:0] rd_data
);

    logic [XW-1:0] x_q [N];
    logic [XW-1:0] x_d [N];
    logic [XW-1:0] taps_s [7];

    // Next-state of the file: clear wins over a write in the same cycle.
    always_comb begin
        x_d = x_q;
        if (clr) begin
            for (int k = 0; k < N; k++) begin
                x_d[k] = '0;
            end
        end else if (we) begin
            x_d[waddr] = wdata;
        end else begin
            x_d = x_q;
        end
    end

    // Register file state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            x_q <= x_d;
        end
    end

    // Window taps i-3..i+3; taps falling outside 0..N-1 read as zero.
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            int j;
            j = int'(win_idx) + k - 32'sd3;
            if ((j >= 32'sd0) && (j < N)) begin
                taps_s[k] = x_q[j[IW-1:0]];
            end else begin
                taps_s[k] = '0;
            end
        end
    end

    assign tap_m3  = taps_s[0];
    assign tap_m2  = taps_s[1];
    assign tap_m1  = taps_s[2];
    assign tap_p1  = taps_s[4];
    assign tap_p2  = taps_s[5];
    assign tap_p3  = taps_s[6];
    assign rd_data = x_q[rd_idx];

endmodule

// File: rtl/gsim_sched.sv
// GSIM sequencer: captures b, runs ITER Gauss-Seidel sweeps through an external
// update unit one index at a time, then streams x[0..N-1] out.
module gsim_sched
    import gsim_pkg::*;
#(
    parameter int ITER = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [BW-1:0] b_in,
    output logic          out_valid,
    output logic [XW-1:0] x_out,
    output logic          upd_req,
    output logic [IW-1:0] upd_idx,
    output logic [XW-1:0] upd_b,
    output logic [XW-1:0] upd_xm1,
    output logic [XW-1:0] upd_xm2,
    output logic [XW-1:0] upd_xm3,
    output logic [XW-1:0] upd_xp1,
    output logic [XW-1:0] upd_xp2,
    output logic [XW-1:0] upd_xp3,
    input  logic          upd_res_valid,
    input  logic [XW-1:0] upd_res,
    output logic          busy
);

    gsim_state_t   state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [15:0]   iter_q, iter_d;
    logic [BW-1:0] b_q [N];
    logic [BW-1:0] b_d [N];
    logic          x_clr_s, x_we_s, act_s;
    logic [XW-1:0] m1_s, m2_s, m3_s, p1_s, p2_s, p3_s, rd_s;

    // Sequencing FSM with load counter, sweep index/iteration and output pointer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        iter_d  = iter_q;
        ptr_d   = ptr_q;
        b_d     = b_q;
        x_clr_s = 1'b0;
        x_we_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_en) begin
                    b_d[0]  = b_in;
                    cnt_d   = IW'(1);
                    x_clr_s = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_en) begin
                    b_d[cnt_q] = b_in;
                    cnt_d      = cnt_q + IW'(1);
                    if (cnt_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        iter_d  = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (upd_res_valid) begin
                    x_we_s = 1'b1;
                    if (idx_q != IW'(N - 1)) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_ISSUE;
                    end else if (iter_q < 16'(ITER - 1)) begin
                        idx_d   = '0;
                        iter_d  = iter_q + 16'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        ptr_d   = '0;
                        state_d = ST_OUT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUT: begin
                ptr_d = ptr_q + IW'(1);
                if (ptr_q == IW'(N - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and b file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            iter_q  <= '0;
            ptr_q   <= '0;
            for (int k = 0; k < N; k++) begin
                b_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            iter_q  <= iter_d;
            ptr_q   <= ptr_d;
            b_q     <= b_d;
        end
    end

    gsim_xfile u_xfile (
        .clk     (clk),
        .reset   (reset),
        .clr     (x_clr_s),
        .we      (x_we_s),
        .waddr   (idx_q),
        .wdata   (upd_res),
        .win_idx (idx_q),
        .tap_m3  (m3_s),
        .tap_m2  (m2_s),
        .tap_m1  (m1_s),
        .tap_p1  (p1_s),
        .tap_p2  (p2_s),
        .tap_p3  (p3_s),
        .rd_idx  (ptr_q),
        .rd_data (rd_s)
    );

    // Operands are only presented while a request is outstanding; zero elsewhere.
    assign act_s     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign upd_req   = (state_q == ST_ISSUE);
    assign upd_idx   = act_s ? idx_q : '0;
    assign upd_b     = act_s ? widen_b(b_q[idx_q]) : '0;
    assign upd_xm1   = act_s ? m1_s : '0;
    assign upd_xm2   = act_s ? m2_s : '0;
    assign upd_xm3   = act_s ? m3_s : '0;
    assign upd_xp1   = act_s ? p1_s : '0;
    assign upd_xp2   = act_s ? p2_s : '0;
    assign upd_xp3   = act_s ? p3_s : '0;
    assign out_valid = (state_q == ST_OUT);
    assign x_out     = (state_q == ST_OUT) ? rd_s : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule
